pmu_i2c_slave: RTL and testbench
================================

// Module: pmu_i2c_slave
// PURPOSE
//  I2C target emulating the PMU register interface that ICE's I2C master drives
//  (write = 7-bit addr W, subaddr, data; read = addr W, subaddr, Sr, addr R, data).
//  Holds a local register file, reports every bus write on a strobe, and serves
//  reads from the file. Used as an on-FPGA PMU stand-in for loopback testing.
// PARAMETERS
//  I2C_ADDR  7'h34  7-bit target address (0x68 write / 0x69 read on the wire)
//  REG_AW    6      register file address width; 2**REG_AW bytes
// PORTS
//  clk         in   1       system clock, >= 8x SCL frequency
//  reset       in   1       synchronous, active-high reset
//  scl         in   1       I2C clock (target never stretches)
//  sda         inout 1      I2C data, open-drain: 1'b0 or 1'bz only
//  host_we     in   1       host write to register file
//  host_addr   in   REG_AW  host read/write address
//  host_wdata  in   8       host write data
//  host_rdata  out  8       register file[host_addr], 1-cycle registered read
//  wr_strobe   out  1       1-cycle pulse per I2C data byte written
//  wr_addr     out  REG_AW  subaddress of that write, held until next strobe
//  wr_data     out  8       data of that write, held until next strobe
//  busy        out  1       high from an addressed START/Sr to STOP or abandon
// BEHAVIOUR
//  Reset: sda released (z); wr_strobe=0; wr_addr=0; wr_data=0; busy=0;
//   host_rdata=0; FSM=IDLE; subaddr=0; register file contents undefined.
//  scl/sda pass through 2-FF synchronizers; edges are detected on synced copies.
//  START/Sr: sda fall while scl high -> ADDR from any state. STOP: sda rise
//   while scl high -> IDLE from any state, sda released.
//  Bits are sampled on scl rise, MSB first; sda is changed only after scl fall.
//  FSM: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
//   ADDR: 8 bits. addr==I2C_ADDR -> ADDR_ACK, busy=1; mismatch -> IGNORE, no ACK.
//   ADDR_ACK: drive sda=0 from the 8th scl fall to the 9th scl fall; then
//    R/W=0 -> SUB; R/W=1 -> RDATA with shift reg loaded from file[subaddr].
//   SUB: 8 bits. Bits [7:REG_AW] nonzero -> NACK (leave sda released), IGNORE.
//    Otherwise latch subaddr, ACK, then WDATA.
//   WDATA: 8 bits -> write file[subaddr], wr_strobe pulse on the cycle after the
//    8th sample, ACK, then WDATA again (multi-byte writes allowed).
//   RDATA: drive each bit (0 -> sda=0, 1 -> z) after scl fall; after 8 bits,
//    release sda and sample master ACK on 9th scl rise: ACK (0) -> reload, RDATA;
//    NACK (1) -> IGNORE.
//   IGNORE: sda released; wait for STOP or START.
//  Subaddr persists across transactions until the next SUB byte.
//  Same-cycle I2C and host write to one address: I2C write wins. Host read in
//   the same cycle as a write to that address returns the old value.
//  STOP/START mid-byte: partial byte is discarded, no write, no strobe.
//  Reset mid-transaction: sda released on the cycle after reset is sampled.
// CONFIGURATION
//  PMU_I2C_SLAVE_AUTOINC_EN defined: subaddr increments modulo 2**REG_AW after
//   each written byte and each read byte the master ACKs (wraps 2**REG_AW-1 -> 0).
//  Not defined: subaddr is fixed for the whole transaction; repeated bytes
//   target the same register.
// STRUCTURE
//  Shared package/include: FSM state encodings, I2C_ADDR default, and R/W bit
//   position constants.
//  One sub-module, i2c_edge_det: 2-FF synchronizer plus rise/fall flags for
//   scl/sda, and START/STOP flags. The register file is inferred inline.
// TESTING
//  Write 0x68,0x10,0x9B,STOP -> ACK on all 3 bytes; file[0x10]=0x9B;
//   one wr_strobe with wr_addr=0x10 and wr_data=0x9B.
//  Host preload file[0x32]=0x5A; send 0x68,0x32,Sr,0x69, read one byte, master
//   NACKs -> byte 0x5A returned; sda released; busy=0 after STOP.
//  Address 0x6A,0x10,0x55 -> sda never driven low; no wr_strobe; busy stays 0.
//  Subaddr 0x45 (REG_AW=6) -> NACK on 2nd byte; following 0x77 ignored, no write.
//  STOP after 4 bits of a data byte, then reset asserted mid-read -> no strobe;
//   FSM=IDLE and sda=z one cycle after reset.
//  AUTOINC_EN: write 0x68,0x3F,0x11,0x22 -> file[0x3F]=0x11, file[0x00]=0x22;
//   macro off -> file[0x3F]=0x22.

Source files
------------

// File: rtl/pmu_i2c_slave_pkg.sv
// Shared definitions for the PMU I2C target stand-in: FSM state encodings,
// default target address, register-file width and address-byte field positions.
package pmu_i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } i2c_state_e;

  // 7-bit target address: 0x68 write / 0x69 read on the wire
  localparam logic [6:0]  I2C_ADDR_DEFAULT = 7'h34;
  localparam int unsigned REG_AW_DEFAULT   = 6;

  // Layout of the address byte as shifted in MSB first
  localparam int unsigned RW_BIT   = 0;
  localparam int unsigned ADDR_LSB = 1;
  localparam int unsigned ADDR_MSB = 7;

  // Bit counter value on the 8th bit of a byte
  localparam logic [2:0]  BIT_LAST = 3'd7;

  // True when the received address byte selects this target
  function automatic logic addr_match(input logic [7:0] rx_byte, input logic [6:0] own_addr);
    return (rx_byte[ADDR_MSB:ADDR_LSB] == own_addr);
  endfunction

endpackage

// File: rtl/pmu_i2c_slave_i2c_edge_det.sv
// i2c_edge_det: two-flop synchronizers on scl/sda plus rise/fall flags and
// START/STOP flags, all derived from the synchronized copies.
module pmu_i2c_slave_i2c_edge_det (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;

  // Synchronize the bus lines and keep one cycle of history for edge detection
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // Idle bus level is high on both lines
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign sda_o      = sda_sync_q[1];
  assign scl_rise_o = scl_sync_q[1] & ~scl_prev_q;
  assign scl_fall_o = ~scl_sync_q[1] & scl_prev_q;
  // sda may only move as a data bit while scl is low; a move with scl steadily high is framing
  assign start_o    = ~sda_sync_q[1] & sda_prev_q & scl_sync_q[1] & scl_prev_q;
  assign stop_o     = sda_sync_q[1] & ~sda_prev_q & scl_sync_q[1] & scl_prev_q;

endmodule

// File: rtl/pmu_i2c_slave.sv
// PMU register-interface I2C target: write = addr W, subaddr, data...;
// read = addr W, subaddr, Sr, addr R, data... Holds a local register file,
// reports each bus write on a strobe and serves reads from the file.
// Optional feature macro: PMU_I2C_SLAVE_AUTOINC_EN (subaddress auto-increment).
module pmu_i2c_slave
  import pmu_i2c_slave_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDR = I2C_ADDR_DEFAULT,
  parameter int unsigned REG_AW   = REG_AW_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              scl_i,
  inout  wire               sda_io,
  input  logic              host_we_i,
  input  logic [REG_AW-1:0] host_addr_i,
  input  logic [7:0]        host_wdata_i,
  output logic [7:0]        host_rdata_o,
  output logic              wr_strobe_o,
  output logic [REG_AW-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o
);

  localparam int unsigned       DEPTH    = 1 << REG_AW;
  localparam logic [REG_AW-1:0] SUB_ZERO = {REG_AW{1'b0}};
  localparam logic [REG_AW-1:0] SUB_ONE  = {{(REG_AW-1){1'b0}}, 1'b1};

`ifdef PMU_I2C_SLAVE_AUTOINC_EN
  localparam logic AUTOINC_EN = 1'b1;
`else
  localparam logic AUTOINC_EN = 1'b0;
`endif

  // Bus events from the synchronizer
  logic sda_s;
  logic scl_rise_s;
  logic scl_fall_s;
  logic start_s;
  logic stop_s;

  // FSM and datapath state
  i2c_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [REG_AW-1:0] sub_q, sub_d;
  logic              oe_q, oe_d;
  logic              busy_q, busy_d;
  logic              rw_q, rw_d;
  logic              strobe_q, strobe_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        host_rdata_q;

  logic [7:0]        rx_byte_s;
  logic [7:0]        rd_byte_s;
  logic [REG_AW-1:0] sub_inc_s;
  logic              i2c_we_s;

  logic [7:0]        mem_q [DEPTH];

  pmu_i2c_slave_i2c_edge_det u_edge_det (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .scl_i      (scl_i),
    .sda_i      (sda_io),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s),
    .start_o    (start_s),
    .stop_o     (stop_s)
  );

  // Open-drain: only ever pull low or release
  assign sda_io = oe_q ? 1'b0 : 1'bz;

  // Byte completed by the bit currently being sampled (only 7 bits need storing)
  assign rx_byte_s = {shift_q, sda_s};
  assign rd_byte_s = mem_q[sub_q];
  assign sub_inc_s = AUTOINC_EN ? (sub_q + SUB_ONE) : sub_q;

  // Next-state and datapath decisions; framing conditions override every state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    sub_d     = sub_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    i2c_we_s  = 1'b0;

    if (stop_s) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_s) begin
      // Any partial byte is dropped; busy is re-decided by the address byte
      state_d = ST_ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          oe_d = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d = rx_byte_s[6:0];
            if (cnt_q == BIT_LAST) begin
              cnt_d = 3'd0;
              if (addr_match(rx_byte_s, I2C_ADDR)) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_byte_s[RW_BIT];
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        // cnt_q=0: waiting for the 8th scl fall; cnt_q=1: holding ACK until the 9th fall
        ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
          if (scl_fall_s) begin
            if (cnt_q == 3'd0) begin
              oe_d  = 1'b1;
              cnt_d = 3'd1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = 3'd0;
              if (state_q != ST_ADDR_ACK) begin
                state_d = ST_WDATA;
              end else if (rw_q) begin
                // First read bit goes out right after the ACK slot ends
                state_d = ST_RDATA;
                shift_d = rd_byte_s[6:0];
                oe_d    = ~rd_byte_s[7];
              end else begin
                state_d = ST_SUB;
              end
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        ST_SUB: begin
          if (scl_rise_s) begin
            shift_d = rx_byte_s[6:0];
            if (cnt_q == BIT_LAST) begin
              cnt_d = 3'd0;
              if ((rx_byte_s >> REG_AW) != 8'd0) begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end else begin
                sub_d   = rx_byte_s[REG_AW-1:0];
                state_d = ST_SUB_ACK;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        ST_WDATA: begin
          if (scl_rise_s) begin
            shift_d = rx_byte_s[6:0];
            if (cnt_q == BIT_LAST) begin
              cnt_d     = 3'd0;
              i2c_we_s  = 1'b1;
              strobe_d  = 1'b1;
              wr_addr_d = sub_q;
              wr_data_d = rx_byte_s;
              sub_d     = sub_inc_s;
              state_d   = ST_WDATA_ACK;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        ST_RDATA: begin
          if (scl_fall_s) begin
            if (cnt_q == BIT_LAST) begin
              // Byte done: release so the master can drive its ACK/NACK
              cnt_d   = 3'd0;
              oe_d    = 1'b0;
              state_d = ST_RACK;
            end else begin
              cnt_d   = cnt_q + 3'd1;
              oe_d    = ~shift_q[6];
              shift_d = {shift_q[5:0], 1'b0};
            end
          end else begin
            cnt_d = cnt_q;
          end
        end

        // cnt_q=0: waiting for the master's ACK bit; cnt_q=1: ACKed, reload on next fall
        ST_RACK: begin
          if (scl_rise_s && (cnt_q == 3'd0)) begin
            if (sda_s == 1'b0) begin
              cnt_d = 3'd1;
              sub_d = sub_inc_s;
            end else begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end
          end else if (scl_fall_s && (cnt_q == 3'd1)) begin
            cnt_d   = 3'd0;
            shift_d = rd_byte_s[6:0];
            oe_d    = ~rd_byte_s[7];
            state_d = ST_RDATA;
          end else begin
            cnt_d = cnt_q;
          end
        end

        ST_IGNORE: begin
          oe_d   = 1'b0;
          busy_d = 1'b0;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // FSM and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      shift_q   <= 7'd0;
      sub_q     <= SUB_ZERO;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      strobe_q  <= 1'b0;
      wr_addr_q <= SUB_ZERO;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      sub_q     <= sub_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
      strobe_q  <= strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Register file writes; the I2C write is issued last so it wins on an address clash
  always_ff @(posedge clk_i) begin
    if (host_we_i) begin
      mem_q[host_addr_i] <= host_wdata_i;
    end
    if (i2c_we_s) begin
      mem_q[sub_q] <= rx_byte_s;
    end
  end

  // Registered host read; returns the pre-write value on a same-cycle write
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      host_rdata_q <= 8'd0;
    end else begin
      host_rdata_q <= mem_q[host_addr_i];
    end
  end

  assign host_rdata_o = host_rdata_q;
  assign wr_strobe_o  = strobe_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_pmu_i2c_slave.sv
// Directed bench for pmu_i2c_slave: host-port vector table plus bit-banged
// I2C master sequences for writes, reads, address/subaddress rejection,
// mid-byte STOP and mid-read reset.
module tb_pmu_i2c_slave;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          scl;
  logic          sda_low;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic [7:0]    host_rdata;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  wire           sda_w;

  assign sda_w = sda_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  always #5 clk = ~clk;

  pmu_i2c_slave #(.I2C_ADDR(7'h34), .REG_AW(AW)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .scl_i        (scl),
    .sda_io       (sda_w),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_rdata_o (host_rdata),
    .wr_strobe_o  (wr_strobe),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .busy_o       (busy)
  );

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int dut_low_cnt = 0;
  int busy_cnt = 0;

  // Event counters sampled away from the active edge
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (!sda_low && (sda_w == 1'b0)) dut_low_cnt++;
    if (busy) busy_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic qd();
    repeat (6) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_low = 1'b0; qd();
    scl = 1'b1;     qd();
    sda_low = 1'b1; qd();
    scl = 1'b0;     qd();
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; qd();
    scl = 1'b1;     qd();
    sda_low = 1'b0; qd();
  endtask

  task automatic wbit(input logic b);
    sda_low = ~b; qd();
    scl = 1'b1;   qd(); qd();
    scl = 1'b0;   qd();
  endtask

  task automatic rbit(output logic b);
    sda_low = 1'b0; qd();
    scl = 1'b1;     qd();
    b = sda_w;      qd();
    scl = 1'b0;     qd();
  endtask

  task automatic wbyte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(v[i]);
    rbit(b);
    ack = ~b;
  endtask

  task automatic rbyte(output logic [7:0] d, input logic m_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~m_ack);
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [7:0] d);
    @(negedge clk);
    host_we   = 1'b0;
    host_addr = a;
    @(posedge clk);
    #1;
    d = host_rdata;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic          chk;
    logic [7:0]    exp;
  } host_vec_t;

  host_vec_t vec [12];

  initial begin
    logic       ack;
    logic       b;
    logic [7:0] d;
    int         s0;
    int         l0;
    int         b0;

    // Host-port vectors: write, registered read, read-during-write returns old data
    vec[0]  = '{1'b1, 6'h05, 8'hA1, 1'b0, 8'h00};
    vec[1]  = '{1'b1, 6'h06, 8'hB2, 1'b0, 8'h00};
    vec[2]  = '{1'b0, 6'h05, 8'h00, 1'b1, 8'hA1};
    vec[3]  = '{1'b0, 6'h06, 8'h00, 1'b1, 8'hB2};
    vec[4]  = '{1'b1, 6'h05, 8'hC3, 1'b1, 8'hA1};
    vec[5]  = '{1'b0, 6'h05, 8'h00, 1'b1, 8'hC3};
    vec[6]  = '{1'b1, 6'h3F, 8'h7E, 1'b0, 8'h00};
    vec[7]  = '{1'b0, 6'h3F, 8'h00, 1'b1, 8'h7E};
    vec[8]  = '{1'b1, 6'h20, 8'hEE, 1'b0, 8'h00};
    vec[9]  = '{1'b0, 6'h20, 8'h00, 1'b1, 8'hEE};
    vec[10] = '{1'b1, 6'h32, 8'h5A, 1'b0, 8'h00};
    vec[11] = '{1'b0, 6'h32, 8'h00, 1'b1, 8'h5A};

    reset      = 1'b1;
    scl        = 1'b1;
    sda_low    = 1'b0;
    host_we    = 1'b0;
    host_addr  = 6'h00;
    host_wdata = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_host_rdata", 32'(host_rdata), 32'h00);
    check("rst_wr_strobe",  32'(wr_strobe),  32'h0);
    check("rst_wr_addr",    32'(wr_addr),    32'h00);
    check("rst_wr_data",    32'(wr_data),    32'h00);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_sda",        32'(sda_w),      32'h1);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      host_we    = vec[i].we;
      host_addr  = vec[i].addr;
      host_wdata = vec[i].wdata;
      @(posedge clk);
      #1;
      if (vec[i].chk) check($sformatf("host_vec%0d", i), 32'(host_rdata), 32'(vec[i].exp));
    end
    @(negedge clk);
    host_we = 1'b0;
    qd();

    // Single-byte write 0x68, 0x10, 0x9B
    s0 = strobe_cnt;
    bus_start();
    wbyte(8'h68, ack); check("wr_ack_addr", 32'(ack), 32'h1);
    wbyte(8'h10, ack); check("wr_ack_sub",  32'(ack), 32'h1);
    wbyte(8'h9B, ack); check("wr_ack_data", 32'(ack), 32'h1);
    check("wr_busy_mid", 32'(busy), 32'h1);
    bus_stop(); qd();
    check("wr_busy_end", 32'(busy), 32'h0);
    check("wr_strobes",  32'(strobe_cnt - s0), 32'd1);
    check("wr_addr",     32'(wr_addr), 32'h10);
    check("wr_data",     32'(wr_data), 32'h9B);
    host_read(6'h10, d); check("wr_file10", 32'(d), 32'h9B);

    // Read 0x32 (preloaded 0x5A) with repeated start, master NACKs
    s0 = strobe_cnt;
    bus_start();
    wbyte(8'h68, ack); check("rd_ack_addrw", 32'(ack), 32'h1);
    wbyte(8'h32, ack); check("rd_ack_sub",   32'(ack), 32'h1);
    bus_start();
    wbyte(8'h69, ack); check("rd_ack_addrr", 32'(ack), 32'h1);
    check("rd_busy_mid", 32'(busy), 32'h1);
    rbyte(d, 1'b0);    check("rd_data", 32'(d), 32'h5A);
    qd();
    check("rd_sda_released", 32'(sda_w), 32'h1);
    bus_stop(); qd();
    check("rd_busy_end", 32'(busy), 32'h0);
    check("rd_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // Foreign address 0x6A: no ACK anywhere, no write, never busy
    s0 = strobe_cnt; l0 = dut_low_cnt; b0 = busy_cnt;
    bus_start();
    wbyte(8'h6A, ack); check("na_ack_addr", 32'(ack), 32'h0);
    wbyte(8'h10, ack); check("na_ack_sub",  32'(ack), 32'h0);
    wbyte(8'h55, ack); check("na_ack_data", 32'(ack), 32'h0);
    bus_stop(); qd();
    check("na_sda_low_cycles", 32'(dut_low_cnt - l0), 32'd0);
    check("na_strobes",        32'(strobe_cnt - s0),  32'd0);
    check("na_busy_cycles",    32'(busy_cnt - b0),    32'd0);
    host_read(6'h10, d); check("na_file10", 32'(d), 32'h9B);

    // Out-of-range subaddress 0x45: NACK, following data ignored
    s0 = strobe_cnt;
    bus_start();
    wbyte(8'h68, ack); check("bs_ack_addr", 32'(ack), 32'h1);
    wbyte(8'h45, ack); check("bs_ack_sub",  32'(ack), 32'h0);
    check("bs_busy_after_nack", 32'(busy), 32'h0);
    wbyte(8'h77, ack); check("bs_ack_data", 32'(ack), 32'h0);
    bus_stop(); qd();
    check("bs_strobes", 32'(strobe_cnt - s0), 32'd0);
    host_read(6'h05, d); check("bs_file05", 32'(d), 32'hC3);

    // STOP after 4 bits of a data byte: nothing written
    s0 = strobe_cnt;
    bus_start();
    wbyte(8'h68, ack); check("ps_ack_addr", 32'(ack), 32'h1);
    wbyte(8'h20, ack); check("ps_ack_sub",  32'(ack), 32'h1);
    wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
    bus_stop(); qd();
    check("ps_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("ps_busy",    32'(busy), 32'h0);
    host_read(6'h20, d); check("ps_file20", 32'(d), 32'hEE);

    // Reset while the target is driving a 0 read bit
    bus_start();
    wbyte(8'h68, ack); check("rr_ack_addrw", 32'(ack), 32'h1);
    wbyte(8'h32, ack); check("rr_ack_sub",   32'(ack), 32'h1);
    bus_start();
    wbyte(8'h69, ack); check("rr_ack_addrr", 32'(ack), 32'h1);
    rbit(b); check("rr_bit7", 32'(b), 32'h0);
    rbit(b); check("rr_bit6", 32'(b), 32'h1);
    @(negedge clk);
    check("rr_sda_driven", 32'(sda_w), 32'h0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rr_sda_released", 32'(sda_w),   32'h1);
    check("rr_busy",         32'(busy),    32'h0);
    check("rr_wr_addr",      32'(wr_addr), 32'h00);
    check("rr_wr_data",      32'(wr_data), 32'h00);
    reset = 1'b0;
    qd();
    scl = 1'b1;
    qd();

    // Two data bytes at the top subaddress
    s0 = strobe_cnt;
    bus_start();
    wbyte(8'h68, ack); check("ai_ack_addr",  32'(ack), 32'h1);
    wbyte(8'h3F, ack); check("ai_ack_sub",   32'(ack), 32'h1);
    wbyte(8'h11, ack); check("ai_ack_data1", 32'(ack), 32'h1);
    wbyte(8'h22, ack); check("ai_ack_data2", 32'(ack), 32'h1);
    bus_stop(); qd();
    check("ai_strobes", 32'(strobe_cnt - s0), 32'd2);
    check("ai_wr_data", 32'(wr_data), 32'h22);
`ifdef PMU_I2C_SLAVE_AUTOINC_EN
    check("ai_wr_addr", 32'(wr_addr), 32'h00);
    host_read(6'h3F, d); check("ai_file3f", 32'(d), 32'h11);
    host_read(6'h00, d); check("ai_file00", 32'(d), 32'h22);
`else
    check("ai_wr_addr", 32'(wr_addr), 32'h3F);
    host_read(6'h3F, d); check("ai_file3f", 32'(d), 32'h22);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
